// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: sweeps operand pairs into an external 4-bit adder and counts result mismatches.
// Defining ADDER_BIST_ERRLOG_EN adds capture of the first failing vector of each sweep.
module adder_bist_ctrl #(
  parameter int LOOP_LIMIT    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       carry_in,
  input  logic [3:0] sum,
  input  logic       carry_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef ADDER_BIST_ERRLOG_EN
  output logic       err_valid,
  output logic [3:0] err_a,
  output logic [3:0] err_b,
  output logic       err_cin,
`endif
  output logic [7:0] err_count,
  output logic [8:0] vec_count
);
  localparam logic [3:0] LAST  = 4'(LOOP_LIMIT - 1);
  localparam logic [3:0] SLAST = 4'(SETTLE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  state_t     state, state_nx;
  logic [3:0] i, j, cnt;
  logic       mismatch, last;
  logic [7:0] err_nx;
  assign mismatch  = {carry_out, sum} != ({1'b0, a} + {1'b0, b} + {4'b0, carry_in});
  assign last      = (i == LAST) && (j == LAST);
  assign err_nx    = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? DRIVE : IDLE;
      DRIVE:   state_nx = SETTLE;
      SETTLE:  state_nx = (cnt == SLAST) ? CHECK : SETTLE;
      CHECK:   state_nx = last ? DONE : DRIVE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // pass is resolved on the final CHECK so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      carry_in  <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
      i         <= '0;
      j         <= '0;
      cnt       <= '0;
`ifdef ADDER_BIST_ERRLOG_EN
      err_valid <= 1'b0;
      err_a     <= '0;
      err_b     <= '0;
      err_cin   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          pass      <= 1'b0;
          err_count <= '0;
          vec_count <= '0;
          i         <= '0;
          j         <= '0;
`ifdef ADDER_BIST_ERRLOG_EN
          err_valid <= 1'b0;
          err_a     <= '0;
          err_b     <= '0;
          err_cin   <= 1'b0;
`endif
        end
        DRIVE: begin
          a        <= i;
          b        <= j;
          carry_in <= i[0];
          cnt      <= '0;
        end
        SETTLE: cnt <= cnt + 4'd1;
        CHECK: begin
          err_count <= err_nx;
          vec_count <= vec_count + 9'd1;
          j         <= (j == LAST) ? 4'd0 : j + 4'd1;
          i         <= (j == LAST) ? i + 4'd1 : i;
          if (last) pass <= err_nx == 8'd0;
`ifdef ADDER_BIST_ERRLOG_EN
          if (mismatch && !err_valid) begin
            err_valid <= 1'b1;
            err_a     <= a;
            err_b     <= b;
            err_cin   <= carry_in;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb_adder_bist_ctrl: three controller instances (8x8/settle 1, 1x1/settle 1, 16x16/settle 2) against faultable adder models.
module tb_adder_bist_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [3:0] a_v[3], b_v[3], s_v[3];
  logic       ci_v[3], co_v[3], busy_v[3], done_v[3], pass_v[3];
  logic [7:0] err_v[3];
  logic [8:0] vec_v[3];
`ifdef ADDER_BIST_ERRLOG_EN
  logic       ev_v[3], ec_v[3];
  logic [3:0] ea_v[3], eb_v[3];
`endif
  int   mode[3] = '{0, 0, 0};
  int   fbit[3] = '{0, 0, 0};
  logic fval[3] = '{1'b0, 1'b0, 1'b0};
  int   cyc = 0;
  int   dcnt[3] = '{0, 0, 0};
  int   done_at[3] = '{0, 0, 0};
  int   prev_vec[3] = '{0, 0, 0};
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  function automatic int lim(input int k);
    return k == 0 ? 8 : (k == 1 ? 1 : 16);
  endfunction

  function automatic int settle(input int k);
    return k == 2 ? 2 : 1;
  endfunction

  // mode 0 good, 1 sum[0] stuck at 0, 2 constant 5'h1F, 3 result bit fb stuck at fv
  function automatic logic [4:0] adder_model(input logic [3:0] x, input logic [3:0] y, input logic c,
                                             input int md, input int fb, input logic fv);
    logic [4:0] r;
    r = 5'(x) + 5'(y) + 5'(c);
    if (md == 1) r[0] = 1'b0;
    if (md == 2) r = 5'h1F;
    if (md == 3) r[fb] = fv;
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_add
    assign {co_v[k], s_v[k]} = adder_model(a_v[k], b_v[k], ci_v[k], mode[k], fbit[k], fval[k]);
  end

  adder_bist_ctrl u_d (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_v[0]), .b(b_v[0]), .carry_in(ci_v[0]),
    .sum(s_v[0]), .carry_out(co_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
`ifdef ADDER_BIST_ERRLOG_EN
    .err_valid(ev_v[0]), .err_a(ea_v[0]), .err_b(eb_v[0]), .err_cin(ec_v[0]),
`endif
    .err_count(err_v[0]), .vec_count(vec_v[0])
  );

  adder_bist_ctrl #(.LOOP_LIMIT(1), .SETTLE_CYCLES(1)) u_o (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_v[1]), .b(b_v[1]), .carry_in(ci_v[1]),
    .sum(s_v[1]), .carry_out(co_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
`ifdef ADDER_BIST_ERRLOG_EN
    .err_valid(ev_v[1]), .err_a(ea_v[1]), .err_b(eb_v[1]), .err_cin(ec_v[1]),
`endif
    .err_count(err_v[1]), .vec_count(vec_v[1])
  );

  adder_bist_ctrl #(.LOOP_LIMIT(16), .SETTLE_CYCLES(2)) u_g (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_v[2]), .b(b_v[2]), .carry_in(ci_v[2]),
    .sum(s_v[2]), .carry_out(co_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
`ifdef ADDER_BIST_ERRLOG_EN
    .err_valid(ev_v[2]), .err_a(ea_v[2]), .err_b(eb_v[2]), .err_cin(ec_v[2]),
`endif
    .err_count(err_v[2]), .vec_count(vec_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // vector n of a sweep is (n / L, n % L) with carry = outer index parity
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] === 1'b1) begin
        dcnt[k]++;
        done_at[k] = cyc;
      end
      if (vec_v[k] != 9'(prev_vec[k]) && vec_v[k] != 9'd0) begin
        int n, oi, oj;
        n  = int'(vec_v[k]) - 1;
        oi = n / lim(k);
        oj = n % lim(k);
        chk($sformatf("seq%0d_v%0d", k, n), {23'd0, a_v[k], b_v[k], ci_v[k]}, (oi << 5) | (oj << 1) | (oi % 2));
      end
      prev_vec[k] = int'(vec_v[k]);
    end
  end

  task automatic model_sweep(input int k, output int errs, output int vld, output int fa, output int fb, output int fc);
    logic [4:0] got;
    int want;
    errs = 0; vld = 0; fa = 0; fb = 0; fc = 0;
    for (int i = 0; i < lim(k); i++)
      for (int j = 0; j < lim(k); j++) begin
        want = i + j + (i % 2);
        got  = adder_model(4'(i), 4'(j), 1'(i % 2), mode[k], fbit[k], fval[k]);
        if (int'(got) != want) begin
          if (vld == 0) begin vld = 1; fa = i; fb = j; fc = i % 2; end
          errs++;
        end
      end
    if (errs > 255) errs = 255;
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_a%0d", k), a_v[k], 0);
    chk($sformatf("rst_b%0d", k), b_v[k], 0);
    chk($sformatf("rst_cin%0d", k), ci_v[k], 0);
    chk($sformatf("rst_busy%0d", k), busy_v[k], 0);
    chk($sformatf("rst_done%0d", k), done_v[k], 0);
    chk($sformatf("rst_pass%0d", k), pass_v[k], 0);
    chk($sformatf("rst_err%0d", k), err_v[k], 0);
    chk($sformatf("rst_vec%0d", k), vec_v[k], 0);
`ifdef ADDER_BIST_ERRLOG_EN
    chk($sformatf("rst_elog%0d", k), {ev_v[k], ea_v[k], eb_v[k], ec_v[k]}, 0);
`endif
  endtask

  task automatic chk_result(input int k, input int st, input int base);
    int errs, vld, fa, fb, fc;
    model_sweep(k, errs, vld, fa, fb, fc);
    chk($sformatf("done_pulses%0d", k), dcnt[k] - base, 1);
    chk($sformatf("latency%0d", k), done_at[k] - st, lim(k) * lim(k) * (2 + settle(k)) + 1);
    chk($sformatf("pass%0d", k), pass_v[k], errs == 0 ? 1 : 0);
    chk($sformatf("err_count%0d", k), err_v[k], errs);
    chk($sformatf("vec_count%0d", k), vec_v[k], lim(k) * lim(k));
    chk($sformatf("idle_busy%0d", k), busy_v[k], 0);
    chk($sformatf("idle_done%0d", k), done_v[k], 0);
`ifdef ADDER_BIST_ERRLOG_EN
    chk($sformatf("err_valid%0d", k), ev_v[k], vld);
    chk($sformatf("err_a%0d", k), ea_v[k], fa);
    chk($sformatf("err_b%0d", k), eb_v[k], fb);
    chk($sformatf("err_cin%0d", k), ec_v[k], fc);
`endif
  endtask

  task automatic run_sweep(input bit repulse);
    int st, t;
    int base[3];
    for (int k = 0; k < 3; k++) base[k] = dcnt[k];
    @(posedge clk); #1; start = 1'b1; st = cyc;
    @(posedge clk); #1; start = 1'b0;
    if (repulse) begin
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; start = 1'b0;
    end
    t = 0;
    while ((dcnt[0] == base[0] || dcnt[1] == base[1] || dcnt[2] == base[2]) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    for (int k = 0; k < 3; k++) chk_result(k, st, base[k]);
  endtask

  task automatic randomize_faults();
    for (int k = 0; k < 3; k++) begin
      mode[k] = int'($urandom_range(0, 3));
      fbit[k] = int'($urandom_range(0, 4));
      fval[k] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int st;
    int base[3];
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst_n = 1'b1;
    run_sweep(1'b0);
    mode[0] = 1; mode[1] = 1; mode[2] = 2;
    run_sweep(1'b0);
    randomize_faults();
    run_sweep(1'b1);
    mode[0] = 0; mode[1] = 0; mode[2] = 0;
    for (int k = 0; k < 3; k++) base[k] = dcnt[k];
    @(posedge clk); #1; start = 1'b1; st = cyc;
    @(posedge clk); #1; start = 1'b0;
    repeat (3 * 20) @(posedge clk);
    #1;
    chk("abort_vec_count", vec_v[0], 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done0", dcnt[0] - base[0], 0);
    chk("abort_no_done2", dcnt[2] - base[2], 0);
    chk("abort_idle0", busy_v[0], 0);
    chk("abort_start_cyc", st > 0 ? 1 : 0, 1);
    run_sweep(1'b0);
    for (int r = 0; r < 3; r++) begin
      randomize_faults();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_sweep(r == 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adder_bist_ctrl.md
ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

Interface
REQ-001 SHALL have parameter LOOP_LIMIT, default 8, number of values swept per operand (legal 1..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, wait cycles between driving a vector and checking it (legal 1..15).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL provide clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL provide rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL provide start  input  1  begin sweep, sampled in IDLE only.
REQ-007 SHALL provide a  output  4  operand A to the 4-bit adder under test.
REQ-008 SHALL provide b  output  4  operand B to the adder.
REQ-009 SHALL provide carry_in  output  1  carry input to the adder.
REQ-010 SHALL provide sum  input  4  adder sum result.
REQ-011 SHALL provide carry_out  input  1  adder carry result.
REQ-012 SHALL provide busy  output  1  high in every state except IDLE.
REQ-013 SHALL provide done  output  1  one-cycle pulse at sweep end.
REQ-014 SHALL provide pass  output  1  sweep verdict, valid from done until next accepted start.
REQ-015 SHALL provide err_count  output  8  mismatching vectors, saturating at 255.
REQ-016 SHALL provide vec_count  output  9  vectors checked so far in current/last sweep.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-018 IDLE -> DRIVE on start=1; start in any other state SHALL be ignored.
REQ-019 DRIVE (1 cycle) SHALL register a=i, b=j, carry_in=i[0] for current indices i (outer), j (inner), both starting at 0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles with a/b/carry_in held stable.
REQ-021 CHECK (1 cycle) SHALL compare {carry_out,sum} against 5-bit a+b+carry_in; mismatch increments err_count (saturating); vec_count increments every CHECK.
REQ-022 After CHECK: j<LOOP_LIMIT-1 -> j+1, DRIVE; else j=0, i+1, DRIVE; on i=j=LOOP_LIMIT-1 -> DONE.
REQ-023 Each vector SHALL take exactly 2+SETTLE_CYCLES cycles; done SHALL assert LOOP_LIMIT^2*(2+SETTLE_CYCLES)+1 cycles after the cycle start is sampled.
REQ-024 DONE (1 cycle) SHALL assert done, register pass=(err_count==0), then return to IDLE.
REQ-025 Accepted start SHALL clear err_count, vec_count, pass, i, j in the same edge.
REQ-026 In IDLE a, b, carry_in SHALL hold last driven values; err_count, vec_count, pass hold until next start.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE and a=0, b=0, carry_in=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, i=j=0.
REQ-028 Reset mid-sweep SHALL abort without asserting done; first start after release begins a fresh sweep from vector (0,0).

Configuration
REQ-029 Macro ADDER_BIST_ERRLOG_EN SHALL, when defined, add outputs err_valid (1), err_a (4), err_b (4), err_cin (1) capturing the first mismatching vector of a sweep; err_valid set on that CHECK, all four cleared by reset and accepted start; later mismatches do not overwrite.
REQ-030 Without ADDER_BIST_ERRLOG_EN those ports and registers SHALL not exist; all other behaviour unchanged.

Verification
REQ-031 Correct adder model, defaults, start pulse -> done exactly 193 cycles after start, pass=1, err_count=0, vec_count=64.
REQ-032 Adder model with sum[0] stuck at 0, defaults -> err_count=32, pass=0, vec_count=64; with ERRLOG: err_a=0, err_b=1, err_cin=0.
REQ-033 LOOP_LIMIT=1, SETTLE_CYCLES=1 -> single vector a=0,b=0,carry_in=0; done 4 cycles after start; vec_count=1.
REQ-034 start re-pulsed during SETTLE and CHECK -> ignored; sweep sequence and done timing identical to REQ-031.
REQ-035 rst_n low for one cycle at vector 20 -> all outputs reset values, no done; subsequent start yields REQ-031 result.
REQ-036 Model returning constant 5'h1F, LOOP_LIMIT=16 -> err_count=255 (saturated), vec_count=256, pass=0.
